// File: rtl/lifegame_row_engine.sv
`default_nettype none
// ============================================================================
// Module      : lifegame_row_engine
// Description : Streaming Game-of-Life generation engine. Rows of the current
//               generation arrive one per beat; the next-generation row for
//               each input row leaves one beat later through a registered
//               output slot. Birth/survive rules are programmable per frame.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               birth_mask[8:0]      - dead cell with k neighbours is born
//               survive_mask[8:0]    - live cell with k neighbours survives
//               in_valid/in_ready    - input row handshake
//               in_row[W-1:0]        - current-generation row (bit 0 leftmost)
//               in_last              - last row of the frame
//               out_valid/out_ready  - output row handshake
//               out_row[W-1:0]       - next-generation row
//               out_last             - last output row of the frame
//               gen_count[GEN_W-1:0] - completed output frames (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module lifegame_row_engine #(
    parameter int W     = 32,
    parameter int WRAP  = 0,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       birth_mask,
    input  logic [8:0]       survive_mask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_row,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_row,
    output logic             out_last,
    output logic [GEN_W-1:0] gen_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_prev;
    logic [W-1:0]     r_cur;
    logic [8:0]       r_birth_rule;
    logic [8:0]       r_survive_rule;
    logic [W-1:0]     r_out_row;
    logic             r_out_last;
    logic             r_out_valid;
    logic [GEN_W-1:0] r_gen_count;

    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_accept;
    logic [W-1:0]     w_next;
    logic [W-1:0]     w_life;
    // Rows extended by one column on each side: index 0 is column -1,
    // index W+1 is column W.
    logic [W+1:0]     w_ep;
    logic [W+1:0]     w_ec;
    logic [W+1:0]     w_en;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    // In FLUSH the row below the last one is the dead border.
    assign w_next      = (r_state == S_FLUSH) ? '0 : in_row;

    generate
        if (WRAP != 0) begin : g_wrap
            assign w_ep = {r_prev[0], r_prev, r_prev[W-1]};
            assign w_ec = {r_cur[0],  r_cur,  r_cur[W-1]};
            assign w_en = {w_next[0], w_next, w_next[W-1]};
        end else begin : g_nowrap
            assign w_ep = {1'b0, r_prev, 1'b0};
            assign w_ec = {1'b0, r_cur,  1'b0};
            assign w_en = {1'b0, w_next, 1'b0};
        end
    endgenerate

    generate
        for (genvar c = 0; c < W; c++) begin : g_col
            logic [3:0] w_n;
            assign w_n = {3'b000, w_ep[c]} + {3'b000, w_ep[c+1]} + {3'b000, w_ep[c+2]}
                       + {3'b000, w_ec[c]}                        + {3'b000, w_ec[c+2]}
                       + {3'b000, w_en[c]} + {3'b000, w_en[c+1]} + {3'b000, w_en[c+2]};
            assign w_life[c] = r_cur[c] ? r_survive_rule[w_n] : r_birth_rule[w_n];
        end
    endgenerate

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = in_last ? S_FLUSH : S_HOLD;
                end
            end
            S_HOLD: begin
                w_in_ready = w_slot_free;
                if (in_valid && w_slot_free) begin
                    w_state_next = in_last ? S_FLUSH : S_HOLD;
                end
            end
            S_FLUSH: begin
                if (w_slot_free) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row window, rules, output slot and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev         <= '0;
            r_cur          <= '0;
            r_birth_rule   <= 9'h008;
            r_survive_rule <= 9'h00C;
            r_out_row      <= '0;
            r_out_last     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_gen_count    <= '0;
        end else begin
            if (r_out_valid && out_ready && r_out_last) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
            // Delivered and not refilled below: slot empties.
            if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_prev         <= '0;
                        r_cur          <= in_row;
                        r_birth_rule   <= birth_mask;
                        r_survive_rule <= survive_mask;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_out_row   <= w_life;
                        r_out_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_prev      <= r_cur;
                        r_cur       <= in_row;
                    end
                end
                S_FLUSH: begin
                    if (w_slot_free) begin
                        r_out_row   <= w_life;
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;
    assign gen_count = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_lifegame_row_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifegame_row_engine
// Description : Self-checking bench for lifegame_row_engine (W=8). Two
//               instances share all inputs: one without wrap (scoreboarded)
//               and one with horizontal wrap (checked on the single-row frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifegame_row_engine;

    logic        clk;
    logic        rst;
    logic [8:0]  birth_mask;
    logic [8:0]  survive_mask;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_row;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_row;
    logic        out_last;
    logic [15:0] gen_count;

    logic        in_ready1;
    logic        out_valid1;
    logic [7:0]  out_row1;
    logic        out_last1;
    logic [15:0] gen_count1;

    lifegame_row_engine #(.W(8), .WRAP(0), .GEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_last     (out_last),
        .gen_count    (gen_count)
    );

    lifegame_row_engine #(.W(8), .WRAP(1), .GEN_W(16)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .in_valid     (in_valid),
        .in_ready     (in_ready1),
        .in_row       (in_row),
        .in_last      (in_last),
        .out_valid    (out_valid1),
        .out_ready    (out_ready),
        .out_row      (out_row1),
        .out_last     (out_last1),
        .gen_count    (gen_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          n_deliv;
    int          n_blocked;
    bit          acc;
    bit          chk_wrap;
    logic [7:0]  exp_wrap;
    logic [8:0]  expq[$];   // {last, row}
    logic [7:0]  got[$];

    // Independent per-cell reference: counts neighbours explicitly.
    function automatic logic [7:0] life_ref(input logic [7:0] p, input logic [7:0] cu,
                                            input logic [7:0] nx, input logic [8:0] b,
                                            input logic [8:0] s, input bit wrap);
        logic [7:0] res;
        int n;
        int cc;
        for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dc = -1; dc <= 1; dc++) begin
                cc = c + dc;
                if (cc < 0 || cc > 7) begin
                    if (!wrap) continue;
                    cc = (cc + 8) % 8;
                end
                n += int'(p[cc]) + int'(nx[cc]);
                if (dc != 0) n += int'(cu[cc]);
            end
            res[c] = cu[c] ? s[n] : b[n];
        end
        return res;
    endfunction

    // One clock cycle: observe at the falling edge, return just after rising edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_deliv++;
            got.push_back(out_row);
            n_cmp++;
            if (expq.size() == 0) begin
                assert (expq.size() != 0) else begin
                    n_bad++;
                    $error("FAIL extra_beat: got row %h last %b, expected no beat", out_row, out_last);
                end
            end else begin
                e = expq.pop_front();
                assert ({out_last, out_row} === e) else begin
                    n_bad++;
                    $error("FAIL out_beat_%0d: got last/row %b/%h expected %b/%h",
                           n_deliv, out_last, out_row, e[8], e[7:0]);
                end
            end
            if (chk_wrap) begin
                n_cmp++;
                assert (out_row1 === exp_wrap) else begin
                    n_bad++;
                    $error("FAIL wrap_row: got %h expected %h", out_row1, exp_wrap);
                end
                chk_wrap = 1'b0;
            end
        end
        acc = in_valid && in_ready;
        if (in_valid && !in_ready) n_blocked++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [7:0] row, input logic last);
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        acc      = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) tick();
        if (!acc) begin
            n_cmp++;
            assert (acc) else begin
                n_bad++;
                $error("FAIL accept_timeout: row %h not accepted, expected accept", row);
            end
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 30 && expq.size() != 0; k++) tick();
        n_cmp++;
        assert (expq.size() == 0) else begin
            n_bad++;
            $error("FAIL drain_timeout: %0d rows outstanding, expected 0", expq.size());
        end
    endtask

    task automatic push_blinker_out();
        expq.push_back(9'h000);
        expq.push_back(9'h008);
        expq.push_back(9'h008);
        expq.push_back(9'h008);
        expq.push_back(9'h100);
    endtask

    task automatic send_blinker();
        send_row(8'h00, 1'b0);
        send_row(8'h00, 1'b0);
        send_row(8'h1C, 1'b0);
        send_row(8'h00, 1'b0);
        send_row(8'h00, 1'b1);
    endtask

    task automatic push_frame4(input logic [31:0] rows, input logic [8:0] b, input logic [8:0] s);
        logic [7:0] p;
        logic [7:0] nx;
        for (int r = 0; r < 4; r++) begin
            p  = (r > 0) ? rows[8*(r-1) +: 8] : 8'h00;
            nx = (r < 3) ? rows[8*(r+1) +: 8] : 8'h00;
            expq.push_back({(r == 3), life_ref(p, rows[8*r +: 8], nx, b, s, 1'b0)});
        end
    endtask

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        assert (act === expv) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fr;
        n_cmp = 0; n_bad = 0; n_deliv = 0; n_blocked = 0;
        acc = 1'b0; chk_wrap = 1'b0; exp_wrap = 8'h00;
        rst = 1'b1; in_valid = 1'b0; in_row = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        birth_mask = 9'h008; survive_mask = 9'h00C;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_row",   16'(out_row),   16'h0);
        check("rst_out_last",  16'(out_last),  16'h0);
        check("rst_gen_count", gen_count,      16'h0);
        check("rst_in_ready",  16'(in_ready),  16'h1);
        rst = 1'b0;
        tick();

        // Blinker, then its outputs fed back
        push_blinker_out();
        send_blinker();
        drain();
        check("blinker_gen", gen_count, 16'd1);
        expq.push_back(9'h000);
        expq.push_back(9'h000);
        expq.push_back(9'h01C);
        expq.push_back(9'h000);
        expq.push_back(9'h100);
        send_row(8'h00, 1'b0);
        send_row(8'h08, 1'b0);
        send_row(8'h08, 1'b0);
        send_row(8'h08, 1'b0);
        send_row(8'h00, 1'b1);
        drain();
        check("feedback_gen", gen_count, 16'd2);

        // Single-row frame, with and without wrap
        expq.push_back(9'h17E);
        chk_wrap = 1'b1; exp_wrap = 8'hFF;
        send_row(8'hFF, 1'b1);
        drain();
        check("wrap_checked", 16'(chk_wrap), 16'h0);
        check("single_gen", gen_count, 16'd3);

        // HighLife frame; masks switched to Conway after the first row
        fr = {8'h00, 8'h01, 8'h05, 8'h07};
        push_frame4(fr, 9'h048, 9'h00C);
        got.delete();
        birth_mask = 9'h048;
        send_row(fr[7:0], 1'b0);
        birth_mask = 9'h008;
        for (int r = 1; r < 4; r++) send_row(fr[8*r +: 8], (r == 3));
        drain();
        n_cmp++;
        assert (got.size() == 4 && got[1][1] === 1'b1) else begin
            n_bad++;
            $error("FAIL highlife_cell: got size %0d, expected row1 bit1 = 1", got.size());
        end

        // Conway frame; masks switched to HighLife after the first row
        push_frame4(fr, 9'h008, 9'h00C);
        got.delete();
        send_row(fr[7:0], 1'b0);
        birth_mask = 9'h048;
        for (int r = 1; r < 4; r++) send_row(fr[8*r +: 8], (r == 3));
        drain();
        birth_mask = 9'h008;
        n_cmp++;
        assert (got.size() == 4 && got[1][1] === 1'b0) else begin
            n_bad++;
            $error("FAIL conway_cell: got size %0d, expected row1 bit1 = 0", got.size());
        end

        // Backpressure: stall 5 cycles after the first out_valid
        n_deliv = 0;
        push_blinker_out();
        send_row(8'h00, 1'b0);
        out_ready = 1'b0;
        send_row(8'h00, 1'b0);
        in_row = 8'h1C;
        in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_out_row",  {7'h0, out_valid, out_row}, 16'h0100);
            check("stall_ctrl",     {14'h0, out_last, in_ready}, 16'h0000);
        end
        out_ready = 1'b1;
        send_row(8'h1C, 1'b0);
        send_row(8'h00, 1'b0);
        send_row(8'h00, 1'b1);
        drain();
        repeat (3) tick();
        check("stall_deliveries", 16'(n_deliv), 16'd5);

        // Reset after two accepted rows, with an undelivered output pending
        out_ready = 1'b0;
        send_row(8'h00, 1'b0);
        send_row(8'h00, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 16'(out_valid), 16'h0);
        check("midrst_gen_count", gen_count,      16'h0);
        check("midrst_in_ready",  16'(in_ready),  16'h1);
        rst = 1'b0;
        out_ready = 1'b1;
        push_blinker_out();
        send_blinker();
        drain();
        check("midrst_gen", gen_count, 16'd1);

        // Back-to-back frames with in_valid held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_deliv = 0;
        n_blocked = 0;
        push_blinker_out();
        push_blinker_out();
        send_blinker();
        send_blinker();
        drain();
        repeat (3) tick();
        check("b2b_deliveries", 16'(n_deliv),   16'd10);
        check("b2b_gen",        gen_count,      16'd2);
        check("b2b_blocked",    16'(n_blocked), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
